// File: rtl/vec_lsu.sv
// vec_lsu: strided vector load/store sequencer in front of data_mem, one 48-bit word per cycle.
// Define VLSU_BOUNDS_CHECK_EN to enable per-word address range checking and the sticky err flag.
module vec_lsu #(
    parameter int LANES     = 6,
    parameter int LANE_W    = 8,
    parameter int CNT_W     = 4,
    parameter int MEM_WORDS = 102
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_we,
    input  logic [31:0]                  req_base,
    input  logic [31:0]                  req_stride,
    input  logic [CNT_W-1:0]             req_count,
    input  logic                         st_valid,
    input  logic [LANES-1:0][LANE_W-1:0] st_data,
    output logic                         st_ready,
    output logic                         ld_valid,
    output logic [LANES-1:0][LANE_W-1:0] ld_data,
    output logic [CNT_W-1:0]             ld_idx,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [31:0]                  mem_addr,
    output logic                         mem_we,
    output logic [LANES-1:0][LANE_W-1:0] mem_wd,
    input  logic [LANES-1:0][LANE_W-1:0] mem_rd
);

    // state   | meaning
    // S_IDLE  | waiting for a request, req_ready high
    // S_LOAD  | issuing one load address per cycle
    // S_STORE | writing one word per store handshake
    // S_DONE  | one-cycle completion pulse, then back to idle
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STORE, S_DONE} state_t;

    state_t           state, state_nx;
    logic [31:0]      addr_q, stride_q;
    logic [CNT_W-1:0] count_q, idx_q;
    logic             accept, last, step, in_range;

    assign accept = (state == S_IDLE) && req_valid;
    assign last   = (idx_q == count_q - CNT_W'(1));
    assign step   = (state == S_LOAD) || ((state == S_STORE) && st_valid);

`ifdef VLSU_BOUNDS_CHECK_EN
    localparam logic [11:0] WORDS_LIM = 12'(MEM_WORDS);
    assign in_range = (addr_q[1:0] == 2'b00) && (addr_q[13:2] < WORDS_LIM)
                      && (addr_q[31:14] == 18'd0);
`else
    assign in_range = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (req_valid) state_nx = (req_count == '0) ? S_DONE : (req_we ? S_STORE : S_LOAD);
            S_LOAD:  if (last) state_nx = S_DONE;
            S_STORE: if (st_valid && last) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == S_IDLE);
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        st_ready  = (state == S_STORE);
        mem_addr  = '0;
        mem_wd    = '0;
        mem_we    = 1'b0;
        if (state == S_LOAD) begin
            mem_addr = addr_q;
        end else if (state == S_STORE) begin
            mem_addr = addr_q;
            mem_wd   = st_data;
            // rst gate keeps a write from slipping through before the state register clears
            mem_we   = st_valid && in_range && !rst;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            stride_q <= '0;
            count_q  <= '0;
            idx_q    <= '0;
            ld_valid <= 1'b0;
            ld_data  <= '0;
            ld_idx   <= '0;
        end else begin
            ld_valid <= 1'b0;
            if (accept) begin
                addr_q   <= req_base;
                stride_q <= req_stride;
                count_q  <= req_count;
                idx_q    <= '0;
            end else if (step) begin
                addr_q <= addr_q + stride_q;
                idx_q  <= idx_q + CNT_W'(1);
            end
            if (state == S_LOAD) begin
                ld_valid <= 1'b1;
                ld_data  <= in_range ? mem_rd : '0;
                ld_idx   <= idx_q;
            end
        end
    end

`ifdef VLSU_BOUNDS_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    err <= 1'b0;
        else if (accept)            err <= 1'b0;
        else if (step && !in_range) err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule
